// File: rtl/parallel_collision_search_pkg.sv
// Shared types, constants and helpers for the parallel SHA-1 collision search.
package parallel_collision_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int DIGEST_W        = 160;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

    // A single lane still needs a one-bit index port.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic logic [31:0] block_word(input logic [511:0] blk, input logic [3:0] idx);
        return blk[32 * (15 - int'(idx)) +: 32];
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20) begin
            return (b & c) | (~b & d);
        end else if (t < 7'd40) begin
            return b ^ c ^ d;
        end else if (t < 7'd60) begin
            return (b & c) | (b & d) | (c & d);
        end else begin
            return b ^ c ^ d;
        end
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20) begin
            return 32'h5A827999;
        end else if (t < 7'd40) begin
            return 32'h6ED9EBA1;
        end else if (t < 7'd60) begin
            return 32'h8F1BBCDC;
        end else begin
            return 32'hCA62C1D6;
        end
    endfunction

endpackage

// File: rtl/parallel_collision_search_lane.sv
// collision_lane: one SHA-1 core, its candidate counter and the leading-zero hit compare.
module collision_lane
    import parallel_collision_search_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             set_i,
    input  logic [CNT_W-1:0] set_val_i,
    input  logic             advance_i,
    input  logic [CNT_W-1:0] step_i,
    input  logic             word_valid_i,
    input  logic [3:0]       word_idx_i,
    input  logic [511:0]     message_i,
    input  logic [4:0]       target_i,
    output logic             ready_o,
    output logic             hit_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         word_s;
    logic [DIGEST_W-1:0] digest_s;
    logic                sha_ready_s;
    logic [7:0]          shamt_s;

    // Counter is reloaded on a new search and stepped between rounds; wrap is intentional.
    always_comb begin
        cnt_d = cnt_q;
        if (set_i) begin
            cnt_d = set_val_i;
        end else if (advance_i) begin
            cnt_d = cnt_q + step_i;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Word 0 of the block is replaced by this lane's counter.
    always_comb begin
        word_s = 32'd0;
        if (word_idx_i == 4'd0) begin
            word_s = 32'(cnt_q);
        end else begin
            word_s = block_word(message_i, word_idx_i);
        end
    end

    sha1 u_sha1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (clear_i),
        .word_valid_i (word_valid_i),
        .init_i       (word_idx_i == 4'd0),
        .word_i       (word_s),
        .ready_o      (sha_ready_s),
        .digest_o     (digest_s)
    );

    // Shifting by the full digest width leaves nothing, so target 0 always hits.
    assign shamt_s = 8'(DIGEST_W) - {3'd0, target_i};
    assign hit_o   = sha_ready_s && ((digest_s >> shamt_s) == '0);
    assign ready_o = sha_ready_s;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sha1.sv
// Single-block SHA-1 compression core: 16 word-load cycles, then one round per cycle for 80 cycles.
module sha1
    import parallel_collision_search_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         word_valid_i,
    input  logic         init_i,
    input  logic [31:0]  word_i,
    output logic         ready_o,
    output logic [159:0] digest_o
);

    logic [15:0][31:0] w_q;
    logic [4:0]        wcnt_q;
    logic [6:0]        round_q;
    logic              run_q;
    logic              ready_q;
    logic [31:0]       a_q, b_q, c_q, d_q, e_q;
    logic [159:0]      digest_q;
    logic [31:0]       w_sum_s, w_new_s, temp_s;
    logic [4:0]        wcnt_next_s;

    // w_q[j] holds W[t+j], so the schedule rolls forward one word per round.
    assign w_sum_s     = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
    assign w_new_s     = {w_sum_s[30:0], w_sum_s[31]};
    assign temp_s      = {a_q[26:0], a_q[31:27]} + sha1_f(round_q, b_q, c_q, d_q)
                       + e_q + sha1_k(round_q) + w_q[0];
    assign wcnt_next_s = init_i ? 5'd1 : (wcnt_q + 5'd1);

    // Word loading, round iteration and final digest capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q      <= '0;
            wcnt_q   <= 5'd0;
            round_q  <= 7'd0;
            run_q    <= 1'b0;
            ready_q  <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            c_q      <= 32'd0;
            d_q      <= 32'd0;
            e_q      <= 32'd0;
            digest_q <= '0;
        end else if (clear_i) begin
            wcnt_q  <= 5'd0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else if (run_q) begin
            w_q     <= {w_new_s, w_q[15:1]};
            a_q     <= temp_s;
            b_q     <= a_q;
            c_q     <= {b_q[1:0], b_q[31:2]};
            d_q     <= c_q;
            e_q     <= d_q;
            round_q <= round_q + 7'd1;
            if (round_q == 7'd79) begin
                run_q    <= 1'b0;
                ready_q  <= 1'b1;
                digest_q <= {SHA1_H0 + temp_s, SHA1_H1 + a_q, SHA1_H2 + {b_q[1:0], b_q[31:2]},
                             SHA1_H3 + c_q, SHA1_H4 + d_q};
            end
        end else if (word_valid_i) begin
            w_q    <= {word_i, w_q[15:1]};
            wcnt_q <= wcnt_next_s;
            if (init_i) begin
                ready_q <= 1'b0;
            end
            if (wcnt_next_s == 5'd16) begin
                wcnt_q  <= 5'd0;
                run_q   <= 1'b1;
                round_q <= 7'd0;
                a_q     <= SHA1_H0;
                b_q     <= SHA1_H1;
                c_q     <= SHA1_H2;
                d_q     <= SHA1_H3;
                e_q     <= SHA1_H4;
            end
        end
    end

    assign ready_o  = ready_q;
    assign digest_o = digest_q;

endmodule

// File: rtl/parallel_collision_search.sv
// Parallel SHA-1 leading-zero search over LANES counter candidates per round.
// Optional search budget (max_digests port) is enabled by defining CSEARCH_LIMIT_EN.
module parallel_collision_search
    import parallel_collision_search_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [4:0]                    target,
    input  logic [511:0]                  message,
    input  logic [CNT_W-1:0]              counter,
    input  logic [CNT_W-1:0]              increment,
`ifdef CSEARCH_LIMIT_EN
    input  logic [31:0]                   max_digests,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [CNT_W-1:0]              result,
    output logic [lane_idx_w(LANES)-1:0]  result_lane,
    output logic [31:0]                   digests_computed
);

    localparam int LIDX_W = lane_idx_w(LANES);

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [4:0]          target_q;
    logic [511:0]        message_q;
    logic [CNT_W-1:0]    inc_q;
    logic                found_q, found_d;
    logic [CNT_W-1:0]    result_q, result_d;
    logic [LIDX_W-1:0]   lane_q, lane_d;
    logic [31:0]         digests_q, digests_d;
`ifdef CSEARCH_LIMIT_EN
    logic [31:0]         max_q;
`endif

    logic                latch_s, lane_set_s, lane_adv_s, lane_clear_s, limit_s;
    logic [LANES-1:0]    ready_s, hit_s;
    logic [CNT_W-1:0]    lane_cnt_s [LANES];
    logic [CNT_W-1:0]    step_s;
    logic [LIDX_W-1:0]   win_s;
    logic [31:0]         digests_sum_s;

    assign step_s        = CNT_W'(LANES) * inc_q;
    assign digests_sum_s = digests_q + 32'(LANES);

`ifdef CSEARCH_LIMIT_EN
    assign limit_s = (max_q != 32'd0) && (digests_sum_s >= max_q);
`else
    assign limit_s = 1'b0;
`endif

    // Lowest-index hitting lane wins.
    always_comb begin
        win_s = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            win_s = hit_s[k] ? LIDX_W'(k) : win_s;
        end
    end

    // Search sequencing; abort overrides everything including a same-cycle start.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        found_d      = found_q;
        result_d     = result_q;
        lane_d       = lane_q;
        digests_d    = digests_q;
        latch_s      = 1'b0;
        lane_set_s   = 1'b0;
        lane_adv_s   = 1'b0;
        lane_clear_s = 1'b0;
        if (abort) begin
            state_d      = ST_IDLE;
            idx_d        = 4'd0;
            found_d      = 1'b0;
            lane_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d      = ST_LOAD;
                        idx_d        = 4'd0;
                        found_d      = 1'b0;
                        result_d     = '0;
                        lane_d       = '0;
                        digests_d    = 32'd0;
                        latch_s      = 1'b1;
                        lane_set_s   = 1'b1;
                        lane_clear_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(WORDS_PER_BLOCK - 1)) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (&ready_s) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    digests_d = digests_sum_s;
                    if (|hit_s) begin
                        state_d  = ST_DONE;
                        found_d  = 1'b1;
                        result_d = lane_cnt_s[win_s];
                        lane_d   = win_s;
                    end else if (limit_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_LOAD;
                        lane_adv_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, result and latched search parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            found_q   <= 1'b0;
            result_q  <= '0;
            lane_q    <= '0;
            digests_q <= 32'd0;
            target_q  <= 5'd0;
            message_q <= '0;
            inc_q     <= '0;
`ifdef CSEARCH_LIMIT_EN
            max_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            result_q  <= result_d;
            lane_q    <= lane_d;
            digests_q <= digests_d;
            if (latch_s) begin
                target_q  <= target;
                message_q <= message;
                inc_q     <= increment;
`ifdef CSEARCH_LIMIT_EN
                max_q     <= max_digests;
`endif
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [CNT_W-1:0] base_s;
        assign base_s = counter + CNT_W'(k) * increment;

        collision_lane #(.CNT_W(CNT_W)) u_lane (
            .clk          (clk),
            .reset_n      (reset_n),
            .clear_i      (lane_clear_s),
            .set_i        (lane_set_s),
            .set_val_i    (base_s),
            .advance_i    (lane_adv_s),
            .step_i       (step_s),
            .word_valid_i (state_q == ST_LOAD),
            .word_idx_i   (idx_q),
            .message_i    (message_q),
            .target_i     (target_q),
            .ready_o      (ready_s[k]),
            .hit_o        (hit_s[k]),
            .cnt_o        (lane_cnt_s[k])
        );
    end

    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign found            = found_q;
    assign result           = result_q;
    assign result_lane      = lane_q;
    assign digests_computed = digests_q;

endmodule

// File: tb/tb_parallel_collision_search.sv
// Randomized bench for parallel_collision_search against a plain-arithmetic SHA-1 search model.
module tb_parallel_collision_search;

    localparam int LANES = 4;
    localparam int CNT_W = 32;
    localparam int ROUND = 98;

    logic         clk = 1'b0;
    logic         reset_n, start, abort;
    logic [4:0]   target;
    logic [511:0] message;
    logic [31:0]  counter, increment;
`ifdef CSEARCH_LIMIT_EN
    logic [31:0]  max_digests;
`endif
    logic         busy, done, found;
    logic [31:0]  result;
    logic [1:0]   result_lane;
    logic [31:0]  digests_computed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parallel_collision_search #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .target           (target),
        .message          (message),
        .counter          (counter),
        .increment        (increment),
`ifdef CSEARCH_LIMIT_EN
        .max_digests      (max_digests),
`endif
        .busy             (busy),
        .done             (done),
        .found            (found),
        .result           (result),
        .result_lane      (result_lane),
        .digests_computed (digests_computed)
    );

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] ref_sha1(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] h [5];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        h = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
        for (int i = 0; i < 80; i++) begin
            if (i < 16) w[i] = blk[511 - 32 * i -: 32];
            else        w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = rol(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rol(b, 30); b = a; a = tmp;
        end
        return {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e};
    endfunction

    function automatic int lead_zeros(input logic [159:0] dg);
        int n;
        n = 0;
        for (int b = 159; b >= 0; b--) begin
            if (dg[b]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [511:0] with_ctr(input logic [511:0] msg, input logic [31:0] c);
        logic [511:0] blk;
        blk = msg;
        blk[511:480] = c;
        return blk;
    endfunction

    function automatic bit cand_hits(input int tgt, input logic [511:0] msg, input logic [31:0] c);
        return lead_zeros(ref_sha1(with_ctr(msg, c))) >= tgt;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    // Candidate n (n = round*LANES + lane) uses counter c0 + n*inc; first hit in order wins.
    task automatic ref_search(input int tgt, input logic [511:0] msg, input logic [31:0] c0,
                              input logic [31:0] inc, input int max_rounds, output bit hit,
                              output logic [31:0] res, output int lane, output int rounds);
        logic [31:0] c;
        hit = 1'b0; res = 32'd0; lane = 0; rounds = 0;
        for (int r = 0; r < max_rounds && !hit; r++) begin
            rounds = r + 1;
            for (int k = 0; k < LANES && !hit; k++) begin
                c = c0 + 32'(r * LANES + k) * inc;
                if (cand_hits(tgt, msg, c)) begin
                    hit = 1'b1; res = c; lane = k;
                end
            end
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first busy cycle.
    task automatic drive_start(input logic [4:0] t, input logic [511:0] m, input logic [31:0] c,
                               input logic [31:0] inc);
        target = t; message = m; counter = c; increment = inc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target = 5'($urandom); message = rand512(); counter = $urandom; increment = $urandom;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy, done, found} !== 3'b000 || result !== 32'd0 || result_lane !== 2'd0
            || digests_computed !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b found=%b result=%h lane=%0d dig=%0d expected all 0",
                     busy, done, found, result, result_lane, digests_computed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_first_round(input string tag);
        int cyc;
        drive_start(5'd0, rand512(), 32'h10, 32'd2);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b expected 1", tag, busy); end
        wait_done(ROUND + 50, cyc);
        n_tests++;
        if (done !== 1'b1 || cyc != ROUND) begin
            n_fail++; $display("FAIL %s latency: got done=%b after %0d cycles expected %0d", tag, done, cyc, ROUND);
        end
        n_tests++;
        if (found !== 1'b1 || result !== 32'h10 || result_lane !== 2'd0 || digests_computed !== 32'd4) begin
            n_fail++;
            $display("FAIL %s outcome: got found=%b result=%h lane=%0d dig=%0d expected 1 10 0 4",
                     tag, found, result, result_lane, digests_computed);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", tag, done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [511:0] msg; logic [31:0] res; bit hit; int lane, rounds, cyc;
        rounds = 0; hit = 1'b0;
        for (int tries = 0; tries < 400 && !(hit && rounds == 2); tries++) begin
            msg = rand512();
            ref_search(2, msg, 32'hFFFFFFFF, 32'd1, 2, hit, res, lane, rounds);
        end
        drive_start(5'd2, msg, 32'hFFFFFFFF, 32'd1);
        wait_done(2 * ROUND + 50, cyc);
        n_tests++;
        if (done !== 1'b1 || found !== hit || result !== res || result_lane !== 2'(lane)
            || digests_computed !== 32'(4 * rounds)) begin
            n_fail++;
            $display("FAIL wrap: got done=%b found=%b result=%h lane=%0d dig=%0d expected 1 %b %h %0d %0d",
                     done, found, result, result_lane, digests_computed, hit, res, lane, 4 * rounds);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [511:0] msg; logic [31:0] c0, inc;
        int cyc;
        bit ok;
        ok = 1'b0;
        for (int tries = 0; tries < 2000 && !ok; tries++) begin
            msg = rand512(); c0 = $urandom; inc = $urandom;
            ok = !cand_hits(1, msg, c0) && cand_hits(1, msg, c0 + inc) && cand_hits(1, msg, c0 + 3 * inc);
        end
        drive_start(5'd1, msg, c0, inc);
        wait_done(ROUND + 50, cyc);
        n_tests++;
        if (!ok || done !== 1'b1 || found !== 1'b1 || result_lane !== 2'd1 || result !== c0 + inc
            || digests_computed !== 32'd4) begin
            n_fail++;
            $display("FAIL priority: got done=%b found=%b lane=%0d result=%h dig=%0d expected 1 1 1 %h 4 (setup=%b)",
                     done, found, result_lane, result, digests_computed, c0 + inc, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_random_search();
        for (int n = 0; n < 6; n++) begin
            int tgt, lane, rounds, cyc;
            logic [511:0] msg; logic [31:0] c0, inc, res;
            bit hit;
            hit = 1'b0;
            for (int tries = 0; tries < 40 && !hit; tries++) begin
                tgt = $urandom_range(0, 5); msg = rand512(); c0 = $urandom; inc = $urandom;
                ref_search(tgt, msg, c0, inc, 8, hit, res, lane, rounds);
            end
            if (!hit) begin
                tgt = 0;
                ref_search(tgt, msg, c0, inc, 8, hit, res, lane, rounds);
            end
            drive_start(5'(tgt), msg, c0, inc);
            if (n == 0) begin
                repeat (20) @(negedge clk);
                start = 1'b1; counter = ~c0;
                @(negedge clk);
                start = 1'b0;
                wait_done(ROUND * rounds + 50, cyc);
                cyc += 21;
            end else begin
                wait_done(ROUND * rounds + 50, cyc);
            end
            n_tests++;
            if (done !== 1'b1 || cyc != ROUND * rounds || found !== 1'b1 || result !== res
                || result_lane !== 2'(lane) || digests_computed !== 32'(LANES * rounds)) begin
                n_fail++;
                $display("FAIL random_%0d: got done=%b cyc=%0d found=%b result=%h lane=%0d dig=%0d expected 1 %0d 1 %h %0d %0d",
                         n, done, cyc, found, result, result_lane, digests_computed,
                         ROUND * rounds, res, lane, LANES * rounds);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        bit seen_done;
        drive_start(5'd31, rand512(), $urandom, $urandom);
        repeat (30) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || found !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait: got busy=%b found=%b done=%b expected 0 0 0", busy, found, done);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: got activity=%b expected 0", seen_done); end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_load();
        drive_start(5'd0, rand512(), $urandom, $urandom);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, found} !== 3'b000 || result !== 32'd0 || result_lane !== 2'd0
            || digests_computed !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_load: got busy=%b done=%b found=%b result=%h lane=%0d dig=%0d expected all 0",
                     busy, done, found, result, result_lane, digests_computed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_first_round("after_reset");
    endtask

`ifdef CSEARCH_LIMIT_EN
    task automatic test_limit();
        logic [511:0] msg; logic [31:0] c0, inc, res; bit hit; int lane, rounds, cyc;
        hit = 1'b1;
        for (int tries = 0; tries < 20 && hit; tries++) begin
            msg = rand512(); c0 = $urandom; inc = $urandom;
            ref_search(31, msg, c0, inc, 2, hit, res, lane, rounds);
        end
        max_digests = 32'd8;
        drive_start(5'd31, msg, c0, inc);
        max_digests = 32'd0;
        wait_done(2 * ROUND + 50, cyc);
        n_tests++;
        if (done !== 1'b1 || cyc != 2 * ROUND || found !== 1'b0 || digests_computed !== 32'd8) begin
            n_fail++;
            $display("FAIL limit: got done=%b cyc=%0d found=%b dig=%0d expected 1 %0d 0 8",
                     done, cyc, found, digests_computed, 2 * ROUND);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        target = 5'd0; message = '0; counter = 32'd0; increment = 32'd0;
`ifdef CSEARCH_LIMIT_EN
        max_digests = 32'd0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_first_round("first_round");
        test_wrap();
        test_priority();
        test_random_search();
        test_abort();
        test_reset_mid_load();
`ifdef CSEARCH_LIMIT_EN
        test_limit();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
